// File: rtl/conv_layer_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// conv_seq_pkg
// Shared types and helpers for the binarized Conv2d layer sequencer.
//   state_t     : sequencer FSM states
//   clog2_min1  : $clog2 that never returns 0, so single-entry ranges
//                 (IC=1, OC=1) still get a 1-bit select/index signal
// ---------------------------------------------------------------------------
package conv_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FETCH = 3'd2,
    ACCUM = 3'd3,
    EMIT  = 3'd4,
    DONE  = 3'd5
  } state_t;

  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/conv_layer_sequencer_if.sv
// ---------------------------------------------------------------------------
// conv_layer_sequencer_if
// Bundles the sequencer's control/handshake signals.
//   start, busy, done            : layer-level controller handshake
//   acc_clr, acc_en              : accumulator strobes to the Conv2d datapath
//   ic_sel, wt_addr              : image-buffer channel select, weight address
//   out_valid, out_ready, out_oc : per-output-channel valid/ready handshake
// modport master : the sequencer side
// modport slave  : controller / datapath / consumer side
// ---------------------------------------------------------------------------
interface conv_layer_sequencer_if import conv_seq_pkg::*; #(
  parameter int IC = 4,
  parameter int OC = 8
);
  localparam int IC_W      = clog2_min1(IC);
  localparam int OC_W      = clog2_min1(OC);
  localparam int WT_ADDR_W = clog2_min1(IC * OC);

  logic                 start;
  logic                 busy;
  logic                 done;
  logic                 acc_clr;
  logic                 acc_en;
  logic [IC_W-1:0]      ic_sel;
  logic [WT_ADDR_W-1:0] wt_addr;
  logic                 out_valid;
  logic                 out_ready;
  logic [OC_W-1:0]      out_oc;

  modport master (
    input  start, out_ready,
    output busy, done, acc_clr, acc_en, ic_sel, wt_addr, out_valid, out_oc
  );

  modport slave (
    output start, out_ready,
    input  busy, done, acc_clr, acc_en, ic_sel, wt_addr, out_valid, out_oc
  );

endinterface

// File: rtl/conv_layer_sequencer.sv
// ---------------------------------------------------------------------------
// conv_layer_sequencer
// Control FSM that walks one binarized Conv2d accumulator through a layer:
// for every output channel it clears the accumulator, fetches and
// accumulates each input channel's weight set, then offers the binarized
// output channel downstream under valid/ready.
//
// Ports
//   clk   : clock
//   rstn  : synchronous, active-low reset (aborts a layer, no done pulse)
//   bus   : conv_layer_sequencer_if.master (see interface for signal list)
//
// Parameters
//   IC, OC     : input / output channels per layer (>= 1)
//   WT_LAT     : weight-memory read latency in cycles (>= 1)
//   WT_ADDR_W  : weight address width (derived)
//
// Timing: start sampled at edge E gives CLEAR in cycle 1; each output
// channel costs 2 + IC*(WT_LAT+1) cycles with ready held high; done is high
// in cycle OC*(2+IC*(WT_LAT+1)) + 1. Every output comes from flops or from
// registered state/counters, so start/out_ready never reach an output
// combinationally.
// ---------------------------------------------------------------------------
module conv_layer_sequencer import conv_seq_pkg::*; #(
  parameter int IC        = 4,
  parameter int OC        = 8,
  parameter int WT_LAT    = 1,
  parameter int WT_ADDR_W = clog2_min1(IC * OC)
) (
  input  logic                          clk,
  input  logic                          rstn,
  conv_layer_sequencer_if.master        bus
);

  localparam int IC_W   = clog2_min1(IC);
  localparam int OC_W   = clog2_min1(OC);
  localparam int WAIT_W = clog2_min1(WT_LAT);

  localparam logic [IC_W-1:0]   IC_LAST   = IC_W'(IC - 1);
  localparam logic [OC_W-1:0]   OC_LAST   = OC_W'(OC - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WT_LAT - 1);

  state_t              state_q, state_d;
  logic [OC_W-1:0]     oc_q, oc_d;
  logic [IC_W-1:0]     ic_q, ic_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;

  logic                busy_q;
  logic                done_q;
  logic                acc_clr_q;
  logic                acc_en_q;
  logic                out_valid_q;

  logic                addr_phase;
  logic [WT_ADDR_W-1:0] wt_addr_calc;

  // Next-state and counter update.
  always_comb begin
    state_d = state_q;
    oc_d    = oc_q;
    ic_d    = ic_q;
    wait_d  = wait_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = CLEAR;
          oc_d    = '0;
          ic_d    = '0;
          wait_d  = '0;
        end
      end
      CLEAR: begin
        state_d = FETCH;
        wait_d  = '0;
      end
      FETCH: begin
        // Address has been stable since entering FETCH; leave after exactly
        // WT_LAT cycles so the ROM data is valid during ACCUM.
        if (wait_q == WAIT_LAST) begin
          state_d = ACCUM;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      ACCUM: begin
        if (ic_q == IC_LAST) begin
          state_d = EMIT;
        end else begin
          ic_d    = ic_q + IC_W'(1);
          state_d = FETCH;
        end
      end
      EMIT: begin
        if (bus.out_ready) begin
          if (oc_q == OC_LAST) begin
            state_d = DONE;
          end else begin
            oc_d    = oc_q + OC_W'(1);
            ic_d    = '0;
            state_d = CLEAR;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        oc_d    = '0;
        ic_d    = '0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM register; strobes are registered from the next state so that they
  // line up with state_q and stay mutually exclusive by construction.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= IDLE;
      oc_q        <= '0;
      ic_q        <= '0;
      wait_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      acc_clr_q   <= 1'b0;
      acc_en_q    <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      oc_q        <= oc_d;
      ic_q        <= ic_d;
      wait_q      <= wait_d;
      busy_q      <= (state_d != IDLE);
      done_q      <= (state_d == DONE);
      acc_clr_q   <= (state_d == CLEAR);
      acc_en_q    <= (state_d == ACCUM);
      out_valid_q <= (state_d == EMIT);
    end
  end

  // Weight address and channel select only carry meaning while a weight
  // set is being fetched or accumulated; elsewhere they are parked at 0.
  assign addr_phase   = (state_q == FETCH) || (state_q == ACCUM);
  assign wt_addr_calc = WT_ADDR_W'(oc_q) * WT_ADDR_W'(IC) + WT_ADDR_W'(ic_q);

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.acc_clr   = acc_clr_q;
  assign bus.acc_en    = acc_en_q;
  assign bus.out_valid = out_valid_q;
  assign bus.ic_sel    = addr_phase ? ic_q : '0;
  assign bus.wt_addr   = addr_phase ? wt_addr_calc : '0;
  assign bus.out_oc    = (state_q == EMIT) ? oc_q : '0;

endmodule
